// File: rtl/sd_spi_responder.sv
// SD card SPI-mode command responder: receives 48-bit command frames, answers R1/R7 after an Ncr gap.
// Latency: response MSB appears on the falling edge NCR_BITS+1 bit times after the end bit is sampled.
// Backpressure: none; bits arriving during Ncr/response are ignored, SD_cs high aborts to idle.
//
// Ports:
//   SD_clk      sole clock; SD_datain sampled on rising edge, SD_dataout driven on falling edge
//   reset       synchronous, active-high
//   SD_cs       card select, active-low
//   SD_datain   host-to-card command bits, MSB first
//   SD_dataout  card-to-host response bits, idles high
//   cmd_valid   one-cycle pulse per accepted frame; cmd_index/cmd_arg hold the last command
//   in_idle     card idle-state flag (R1 bit 0); state is the FSM encoding for debug
//
// Optional feature: define SD_CRC_CHECK_EN to check CRC7 on CMD0/CMD8 (mismatch answers 0x08|in_idle).
module sd_spi_responder #(
  parameter int NCR_BITS        = 16,
  parameter int ACMD41_BUSY_CNT = 3
) (
  input  logic        SD_clk,
  input  logic        reset,
  input  logic        SD_cs,
  input  logic        SD_datain,
  output logic        SD_dataout,
  output logic        cmd_valid,
  output logic [5:0]  cmd_index,
  output logic [31:0] cmd_arg,
  output logic        in_idle,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    RX_WAIT = 3'd0,
    RX_CMD  = 3'd1,
    DECODE  = 3'd2,
    NCR     = 3'd3,
    TX      = 3'd4
  } state_t;

  localparam int             CW       = (ACMD41_BUSY_CNT < 1) ? 1 : $clog2(ACMD41_BUSY_CNT + 1);
  localparam logic [CW-1:0]  BUSY_MAX = CW'(ACMD41_BUSY_CNT);
  localparam logic [6:0]     NCR_LAST = 7'(NCR_BITS - 1);

  state_t        st;
  logic          got_start;   // previous RX_WAIT sample was a 0 (start bit candidate)
  logic [6:0]    bit_cnt;     // shared bit counter for RX_CMD, NCR and TX
  logic [44:0]   shreg;       // index(6) + argument(32) + CRC7(7); end bit is checked live
  logic [39:0]   resp_sr;     // response, left-aligned; MSB is the bit on the wire
  logic          resp_long;   // 40-bit R7 instead of 8-bit R1
  logic          app_flag;
  logic [CW-1:0] acmd_cnt;

  logic [5:0]    d_idx;
  logic [31:0]   d_arg;
  logic [6:0]    d_crc;
  logic          crc_bad;
  logic [7:0]    r1;
  logic [39:0]   dec_resp;
  logic          dec_long;
  logic          nxt_idle;
  logic          nxt_app;
  logic [CW-1:0] nxt_cnt;

  assign state = st;
  assign d_idx = shreg[44:39];
  assign d_arg = shreg[38:7];
  assign d_crc = shreg[6:0];

`ifdef SD_CRC_CHECK_EN
  // CRC7, polynomial x^7+x^3+1, init 0, over start+transmission+index+argument.
  function automatic logic [6:0] crc7(input logic [39:0] d);
    logic [6:0] c;
    logic       fb;
    c = '0;
    for (int i = 39; i >= 0; i--) begin
      fb = d[i] ^ c[6];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction

  assign crc_bad = ((d_idx == 6'd0) || (d_idx == 6'd8)) &&
                   (crc7({2'b01, d_idx, d_arg}) != d_crc);
`else
  logic unused_crc;
  assign unused_crc = ^d_crc;
  assign crc_bad    = 1'b0;
`endif

  // Response and card-state update for the frame held in shreg; consumed only in DECODE.
  always_comb begin
    r1       = {7'b0, in_idle};
    dec_resp = {r1, 32'h0};
    dec_long = 1'b0;
    nxt_idle = in_idle;
    nxt_app  = 1'b0;        // app flag survives only into the command right after CMD55
    nxt_cnt  = acmd_cnt;
    if (crc_bad) begin
      dec_resp = {r1 | 8'h08, 32'h0};
      nxt_app  = app_flag;  // rejected frame leaves card state untouched
    end else begin
      case (d_idx)
        6'd0: begin
          nxt_idle = 1'b1;
          nxt_cnt  = '0;
          dec_resp = {8'h01, 32'h0};
        end
        6'd8: begin
          dec_resp = {r1, 8'h00, 8'h00, 4'h0, d_arg[11:8], d_arg[7:0]};
          dec_long = 1'b1;
        end
        6'd55: begin
          nxt_app = 1'b1;
        end
        6'd41: begin
          if (app_flag) begin
            if (acmd_cnt < BUSY_MAX) begin
              nxt_cnt  = acmd_cnt + 1'b1;
              dec_resp = {8'h01, 32'h0};
            end else begin
              nxt_idle = 1'b0;
              dec_resp = 40'h0;
            end
          end else begin
            dec_resp = {r1 | 8'h04, 32'h0};
          end
        end
        default: begin
          dec_resp = {r1 | 8'h04, 32'h0};
        end
      endcase
    end
  end

  always_ff @(posedge SD_clk) begin
    if (reset) begin
      st        <= RX_WAIT;
      got_start <= 1'b0;
      bit_cnt   <= '0;
      shreg     <= '0;
      resp_sr   <= '0;
      resp_long <= 1'b0;
      cmd_valid <= 1'b0;
      cmd_index <= '0;
      cmd_arg   <= '0;
      in_idle   <= 1'b1;
      app_flag  <= 1'b0;
      acmd_cnt  <= '0;
    end else begin
      cmd_valid <= 1'b0;
      if (SD_cs) begin
        st        <= RX_WAIT;
        got_start <= 1'b0;
      end else begin
        case (st)
          RX_WAIT: begin
            if (got_start && SD_datain) begin
              st        <= RX_CMD;
              bit_cnt   <= '0;
              got_start <= 1'b0;
            end else begin
              got_start <= ~SD_datain;
            end
          end
          RX_CMD: begin
            if (bit_cnt == 7'd45) begin
              // End bit: a 0 here means a corrupt frame, dropped silently.
              st <= SD_datain ? DECODE : RX_WAIT;
            end else begin
              shreg   <= {shreg[43:0], SD_datain};
              bit_cnt <= bit_cnt + 7'd1;
            end
          end
          DECODE: begin
            cmd_valid <= 1'b1;
            cmd_index <= d_idx;
            cmd_arg   <= d_arg;
            in_idle   <= nxt_idle;
            app_flag  <= nxt_app;
            acmd_cnt  <= nxt_cnt;
            resp_sr   <= dec_resp;
            resp_long <= dec_long;
            bit_cnt   <= '0;
            st        <= NCR;
          end
          NCR: begin
            if (bit_cnt == NCR_LAST) begin
              bit_cnt <= '0;
              st      <= TX;
            end else begin
              bit_cnt <= bit_cnt + 7'd1;
            end
          end
          TX: begin
            if (bit_cnt == (resp_long ? 7'd39 : 7'd7)) begin
              st <= RX_WAIT;
            end else begin
              resp_sr <= {resp_sr[38:0], 1'b0};
              bit_cnt <= bit_cnt + 7'd1;
            end
          end
          default: st <= RX_WAIT;
        endcase
      end
    end
  end

  // Output changes only on the falling edge so the host can sample on the rising edge.
  always_ff @(negedge SD_clk) begin
    if (reset || (st != TX)) SD_dataout <= 1'b1;
    else                     SD_dataout <= resp_sr[39];
  end

endmodule

// File: tb/tb_sd_spi_responder.sv
module tb_sd_spi_responder;

  localparam int NCR  = 16;
  localparam int BUSY = 3;
  localparam int MAXC = 8192;
  localparam int FULL = NCR + 48;

`ifdef SD_CRC_CHECK_EN
  localparam logic [7:0] BAD_CRC_R1 = 8'h09;
`else
  localparam logic [7:0] BAD_CRC_R1 = 8'h01;
`endif

  logic        SD_clk = 1'b0;
  logic        reset = 1'b1;
  logic        SD_cs = 1'b1;
  logic        SD_datain = 1'b1;
  logic        SD_dataout;
  logic        cmd_valid;
  logic [5:0]  cmd_index;
  logic [31:0] cmd_arg;
  logic        in_idle;
  logic [2:0]  state;

  sd_spi_responder #(.NCR_BITS(NCR), .ACMD41_BUSY_CNT(BUSY)) dut (
    .SD_clk(SD_clk), .reset(reset), .SD_cs(SD_cs), .SD_datain(SD_datain),
    .SD_dataout(SD_dataout), .cmd_valid(cmd_valid), .cmd_index(cmd_index),
    .cmd_arg(cmd_arg), .in_idle(in_idle), .state(state)
  );

  always #5 SD_clk = ~SD_clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;          // number of rising edges seen so far
  bit chk_en = 1'b0;

  // Expected wire/debug values indexed by rising-edge number.
  logic       exp_do [MAXC];
  logic [2:0] exp_st [MAXC];
  logic       exp_cv [MAXC];
  logic       act_do [MAXC];

  // Card model state.
  logic        m_idle;
  logic        m_app;
  int          m_cnt;
  logic [5:0]  m_idx;
  logic [31:0] m_arg;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

`ifdef SD_CRC_CHECK_EN
  // Long division by x^7+x^3+1 (0x89) of the 40 frame bits followed by 7 zeros.
  function automatic logic [6:0] crc_div(input logic [39:0] d);
    logic [46:0] m;
    m = {d, 7'b0};
    for (int i = 46; i >= 7; i--)
      if (m[i]) m[i -: 8] = m[i -: 8] ^ 8'h89;
    return m[6:0];
  endfunction
`endif

  // Card behaviour: response for one accepted command plus its state effect.
  task automatic model(input logic [5:0] idx, input logic [31:0] arg, input logic [6:0] crc,
                       output logic [39:0] r, output int len);
    logic [7:0] s;
    logic       bad;
    s   = {7'b0, m_idle};
    len = 8;
    bad = 1'b0;
`ifdef SD_CRC_CHECK_EN
    if ((idx == 6'd0 || idx == 6'd8) && crc != crc_div({2'b01, idx, arg})) bad = 1'b1;
`endif
    if (bad) begin
      r = {s | 8'h08, 32'h0};
    end else if (idx == 6'd0) begin
      m_idle = 1'b1; m_cnt = 0; m_app = 1'b0;
      r = {8'h01, 32'h0};
    end else if (idx == 6'd8) begin
      r = {s, 16'h0000, 4'h0, arg[11:0]};
      len = 40; m_app = 1'b0;
    end else if (idx == 6'd55) begin
      r = {s, 32'h0}; m_app = 1'b1;
    end else if (idx == 6'd41 && m_app) begin
      if (m_cnt < BUSY) begin m_cnt++; r = {8'h01, 32'h0}; end
      else begin m_idle = 1'b0; r = 40'h0; end
      m_app = 1'b0;
    end else begin
      r = {s | 8'h04, 32'h0}; m_app = 1'b0;
    end
    m_idx = idx;
    m_arg = arg;
  endtask

  // Drive one bit just after a falling edge; pc is the rising edge that samples it.
  task automatic drive(input logic b, input logic cs, output int pc);
    @(negedge SD_clk);
    #1;
    SD_datain = b;
    SD_cs = cs;
    pc = cyc + 1;
  endtask

  task automatic send_frame(input logic [47:0] f, input int tail, output logic [39:0] got);
    int pc, pend, len;
    logic [39:0] r;
    got = '0;
    len = 0;
    pend = 0;
    for (int i = 0; i < 48; i++) begin
      drive(f[47-i], 1'b0, pc);
      if (i >= 1 && i <= 46) exp_st[pc] = 3'd1;
    end
    pend = pc;
    if (f[0]) begin
      model(f[45:40], f[39:8], f[7:1], r, len);
      exp_st[pend] = 3'd2;
      exp_cv[pend+1] = 1'b1;
      for (int k = 1; k <= NCR; k++) exp_st[pend+k] = 3'd3;
      for (int i = 0; i < len; i++) begin
        exp_st[pend+NCR+1+i] = 3'd4;
        exp_do[pend+NCR+2+i] = r[39-i];
      end
    end
    for (int i = 0; i < tail; i++) drive(1'b1, 1'b0, pc);
    if (f[0] && tail >= NCR + len + 2)
      for (int i = 0; i < len; i++) got = {got[38:0], act_do[pend+NCR+2+i]};
  endtask

  task automatic do_reset(input int n);
    int pc;
    @(negedge SD_clk);
    #1;
    reset = 1'b1;
    pc = cyc + 1;
    for (int k = pc; k < MAXC; k++) begin
      exp_st[k] = 3'd0;
      exp_cv[k] = 1'b0;
      if (k > pc) exp_do[k] = 1'b1;
    end
    m_idle = 1'b1; m_app = 1'b0; m_cnt = 0; m_idx = '0; m_arg = '0;
    repeat (n) @(negedge SD_clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic chk_regs(input string nm);
    chk({nm, "_idx"}, cmd_index, m_idx);
    chk({nm, "_arg"}, cmd_arg, m_arg);
    chk({nm, "_idle"}, in_idle, m_idle);
    chk({nm, "_state"}, state, 3'd0);
  endtask

  // Rising-edge compare: SD_dataout was set on the previous falling edge.
  initial forever begin
    @(posedge SD_clk);
    cyc++;
    if (cyc < MAXC) begin
      act_do[cyc] = SD_dataout;
      if (chk_en) chk("dataout", SD_dataout, exp_do[cyc]);
    end
  end

  // Falling-edge compare of the rising-edge registered outputs.
  initial forever begin
    @(negedge SD_clk);
    if (chk_en && cyc < MAXC) begin
      chk("state", state, exp_st[cyc]);
      chk("cmd_valid", cmd_valid, exp_cv[cyc]);
    end
  end

  initial begin
    logic [39:0] got;
    int pc;
    for (int k = 0; k < MAXC; k++) begin
      exp_do[k] = 1'b1; exp_st[k] = 3'd0; exp_cv[k] = 1'b0; act_do[k] = 1'b1;
    end
    m_idle = 1'b1; m_app = 1'b0; m_cnt = 0; m_idx = '0; m_arg = '0;

    repeat (3) @(negedge SD_clk);
    #1;
    reset = 1'b0;
    chk_en = 1'b1;
    chk("rst_dataout", SD_dataout, 1'b1);
    chk("rst_cmd_valid", cmd_valid, 1'b0);
    chk_regs("rst");

    send_frame(48'h400000000095, FULL, got);
    chk("cmd0_resp", got[7:0], 8'h01);
    chk_regs("cmd0");

    send_frame(48'h48000001AA87, FULL, got);
    chk("cmd8_resp", got, 40'h01000001AA);
    chk_regs("cmd8");

    send_frame(48'h4000000000FF, FULL, got);
    chk("cmd0_badcrc_resp", got[7:0], BAD_CRC_R1);

    send_frame(48'h6940000000FF, FULL, got);
    chk("cmd41_noapp_resp", got[7:0], 8'h05);

    for (int n = 0; n < 4; n++) begin
      send_frame(48'h7700000000FF, FULL, got);
      chk("cmd55_resp", got[7:0], 8'h01);
      send_frame(48'h6940000000FF, FULL, got);
      chk("acmd41_resp", got[7:0], (n < 3) ? 8'h01 : 8'h00);
    end
    chk_regs("acmd41_done");

    send_frame(48'h7700000000FF, FULL, got);
    chk("cmd55_ready_resp", got[7:0], 8'h00);
    send_frame(48'h6940000000FF, FULL, got);
    chk("acmd41_sat_resp", got[7:0], 8'h00);

    send_frame(48'h5100000000FF, FULL, got);
    chk("cmd17_resp", got[7:0], 8'h04);
    chk_regs("cmd17");

    // End bit 0: dropped, no response and no state change.
    send_frame(48'h400000000094, 30, got);
    chk_regs("endbit0");

    // Deselect at bit 20 of a CMD8, then a full CMD0.
    for (int i = 0; i < 20; i++) begin
      drive(got[0] ^ got[0] ^ logic'((48'h48000001AA87 >> (47 - i)) & 48'h1), 1'b0, pc);
      if (i >= 1) exp_st[pc] = 3'd1;
    end
    repeat (3) drive(1'b1, 1'b1, pc);
    chk_regs("cs_abort");
    send_frame(48'h400000000095, FULL, got);
    chk("cmd0_after_abort_resp", got[7:0], 8'h01);
    chk_regs("cmd0_after_abort");

    // Reset in the middle of a CMD8 response.
    send_frame(48'h48000001AA87, NCR + 10, got);
    do_reset(3);
    repeat (50) drive(1'b1, 1'b0, pc);
    chk_regs("mid_resp_reset");

    send_frame(48'h7700000000FF, FULL, got);
    chk("cmd55_after_reset_resp", got[7:0], 8'h01);

    chk_en = 1'b0;
    repeat (2) @(negedge SD_clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sd_spi_responder.md
SD_SPI_RESPONDER -- requirements
Module: sd_spi_responder

Interface
REQ-001 SHALL have parameter NCR_BITS, default 16, meaning idle (all-ones) bit times between command end bit and response start; legal range 8..64.
REQ-002 SHALL have parameter ACMD41_BUSY_CNT, default 3, meaning the number of ACMD41 commands answered 0x01 before the card reports ready.
REQ-003 SHALL have ports SD_clk (input, 1, sole clock) and reset (input, 1, synchronous, active-high).
REQ-004 SHALL have port SD_cs (input, 1, card select, active-low).
REQ-005 SHALL have port SD_datain (input, 1, host-to-card command bits, MSB first).
REQ-006 SHALL have port SD_dataout (output, 1, card-to-host response bits, idles high).
REQ-007 SHALL have port cmd_valid (output, 1, one-cycle pulse per accepted command frame).
REQ-008 SHALL have ports cmd_index (output, 6, last command index) and cmd_arg (output, 32, last argument).
REQ-009 SHALL have port in_idle (output, 1, card idle-state flag, R1 bit 0).
REQ-010 SHALL have port state (output, 3, current FSM state encoding for debug).

Function
REQ-011 SHALL sample SD_datain on rising SD_clk and update SD_dataout only on falling SD_clk.
REQ-012 SHALL use FSM states RX_WAIT=0, RX_CMD=1, DECODE=2, NCR=3, TX=4.
REQ-013 In RX_WAIT, with SD_cs=0, a sampled 0 followed by a sampled 1 (start+transmission bit) SHALL enter RX_CMD; otherwise remain.
REQ-014 RX_CMD SHALL shift in the remaining 46 bits (index, argument, CRC7, end bit) and then enter DECODE.
REQ-015 An end bit of 0 SHALL discard the frame, return to RX_WAIT, and produce no response or cmd_valid.
REQ-016 DECODE SHALL last one cycle, pulse cmd_valid, latch cmd_index/cmd_arg, form the response, and enter NCR.
REQ-017 CMD0 SHALL set in_idle=1, clear the ACMD41 counter and app flag, and respond R1=0x01.
REQ-018 CMD8 SHALL respond R7 (40 bits) = {R1, 0x00, 0x00, 4'b0000, arg[11:8], arg[7:0]}.
REQ-019 CMD55 SHALL set the app flag and respond R1={7'b0, in_idle}.
REQ-020 CMD41 with app flag set SHALL increment the ACMD41 counter and respond 0x01 while count < ACMD41_BUSY_CNT; on the next ACMD41 it SHALL clear in_idle and respond 0x00.
REQ-021 Any other command, including CMD41 without the app flag, SHALL respond R1=0x04|in_idle (illegal command).
REQ-022 The app flag SHALL clear after any command other than CMD55.
REQ-023 NCR SHALL hold SD_dataout=1 for exactly NCR_BITS falling edges, then enter TX.
REQ-024 TX SHALL drive the response MSB first, one bit per falling edge (8 or 40 bits), then drive 1 and return to RX_WAIT.
REQ-025 Bits sampled during NCR/TX SHALL be ignored; no command overlap.
REQ-026 SD_cs=1 in any state SHALL abort to RX_WAIT next rising edge with SD_dataout=1 at the next falling edge; in_idle, counter, and app flag are kept.
REQ-027 The ACMD41 counter SHALL saturate at ACMD41_BUSY_CNT and never wrap.

Reset
REQ-028 reset=1 at a rising edge SHALL force state=RX_WAIT, cmd_valid=0, cmd_index=0, cmd_arg=0, in_idle=1, app flag=0, counter=0.
REQ-029 SD_dataout SHALL be 1 at the first falling edge with reset=1 and SHALL remain 1 throughout reset.
REQ-030 Reset asserted mid-frame or mid-response SHALL drop the transfer with no further response bits.

Configuration
REQ-031 With macro SD_CRC_CHECK_EN defined, CRC7 (polynomial x^7+x^3+1, init 0) over the first 40 frame bits SHALL be checked for CMD0 and CMD8 only; on mismatch the block SHALL respond R1=0x08|in_idle and apply no state change.
REQ-032 Without SD_CRC_CHECK_EN, the CRC field SHALL be ignored for all commands.

Verification
REQ-033 Frame 40 00 00 00 00 95 -> cmd_valid pulse; cmd_index=0; 16 ones; then 0x01 on SD_dataout; in_idle=1.
REQ-034 Frame 48 00 00 01 AA 87 -> 16 ones; then 0x01 00 00 01 AA.
REQ-035 Sequence (77..FF, 69 40 00 00 00 FF) repeated 4 times -> ACMD41 responses 01, 01, 01, 00; in_idle=0 after the 4th.
REQ-036 Frame 40 00 00 00 00 FF with SD_CRC_CHECK_EN defined -> response 0x09; without the macro -> 0x01.
REQ-037 Frame 51 00 00 00 00 FF (CMD17) after init -> response 0x04.
REQ-038 SD_cs raised at bit 20 of a CMD8 frame, then a full CMD0 frame -> no CMD8 response; CMD0 answered 0x01.
